// File: rtl/ysyx_22050612_pkg.sv
// rtl/ysyx_22050612_pkg.sv - shared IFU types and constants
package ysyx_22050612_pkg;

  localparam int          INST_W           = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    ST_REQ         = 3'd0,
    ST_WAIT_RSP    = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_COMMIT = 3'd3,
    ST_FAULT       = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050612_ifu_perf.sv
// rtl/ysyx_22050612_ifu_perf.sv - fetch/stall counters, instantiated only under IFU_PERF_EN
module ysyx_22050612_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_done,
  input  logic        stall,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_done) fetch_cnt <= fetch_cnt + 64'd1;
      if (stall)      stall_cnt <= stall_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - multi-cycle instruction fetch unit
// Optional performance counters enabled by defining IFU_PERF_EN.
module ysyx_22050612_ifu
  import ysyx_22050612_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [XLEN-1:0]   imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_dnpc,
  output logic              fetch_err,
  output logic [XLEN-1:0]   fetch_err_pc,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
);

  ifu_state_e      state;
  ifu_state_e      state_nxt;
  logic [XLEN-1:0] pc;
  logic            misaligned;
  logic            commit_take;

  assign misaligned    = (pc[1:0] != 2'b00);
  assign imem_req_addr = {pc[XLEN-1:3], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    commit_take    = 1'b0;
    case (state)
      ST_REQ: begin
        if (misaligned) begin
          state_nxt = ST_FAULT;
        end else begin
          imem_req_valid = ~rst;
          if (imem_req_ready) state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (imem_rsp_valid) state_nxt = imem_rsp_err ? ST_FAULT : ST_ISSUE;
      end
      ST_ISSUE: begin
        inst_valid = 1'b1;
        // Same-cycle commit lets a single-cycle execute skip WAIT_COMMIT.
        if (inst_ready) begin
          commit_take = commit_valid;
          state_nxt   = commit_valid ? ST_REQ : ST_WAIT_COMMIT;
        end
      end
      ST_WAIT_COMMIT: begin
        if (commit_valid) begin
          commit_take = 1'b1;
          state_nxt   = ST_REQ;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      inst         <= '0;
      inst_pc      <= '0;
      fetch_err    <= 1'b0;
      fetch_err_pc <= '0;
    end else begin
      if (state == ST_REQ && misaligned) begin
        fetch_err    <= 1'b1;
        fetch_err_pc <= pc;
      end
      if (state == ST_WAIT_RSP && imem_rsp_valid) begin
        if (imem_rsp_err) begin
          fetch_err    <= 1'b1;
          fetch_err_pc <= pc;
        end else begin
          inst    <= pc[2] ? imem_rsp_data[2*INST_W-1:INST_W] : imem_rsp_data[INST_W-1:0];
          inst_pc <= pc;
        end
      end
      if (commit_take) pc <= commit_dnpc;
    end
  end

`ifdef IFU_PERF_EN
  ysyx_22050612_ifu_perf u_perf (
    .clk        (clk),
    .rst        (rst),
    .fetch_done (state == ST_WAIT_RSP && imem_rsp_valid && !imem_rsp_err),
    .stall      (state == ST_REQ || state == ST_WAIT_RSP),
    .fetch_cnt  (perf_fetch_cnt),
    .stall_cnt  (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = 64'd0;
  assign perf_stall_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb/tb_ysyx_22050612_ifu.sv - scoreboard bench for the instruction fetch unit
`timescale 1ns/1ps
module tb_ysyx_22050612_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [63:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        commit_valid;
  logic [63:0] commit_dnpc;
  logic        fetch_err;
  logic [63:0] fetch_err_pc, perf_fetch_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  ysyx_22050612_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .commit_valid(commit_valid), .commit_dnpc(commit_dnpc),
    .fetch_err(fetch_err), .fetch_err_pc(fetch_err_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  typedef struct { logic [31:0] inst; logic [63:0] pc; } iss_t;
  logic [63:0] req_q[$];
  iss_t        iss_q[$];

  int n_cmp = 0, n_bad = 0;
  int req_hs = 0, iss_hs = 0, ivalid_cycles = 0;
  int lat = 1, req_stall = 0;
  bit spur = 0;
  logic [63:0] err_addr = '1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 64'h00000013_00100093;
      64'h8000_0008: return 64'h12345678_cafef00d;
      64'h8000_1000: return 64'h0000006f_0000006f;
      default:       return 64'h0;
    endcase
  endfunction

  // Memory model: drives at negedge+2, response lat cycles after the request handshake.
  initial begin : memory
    bit pend;
    int cnt;
    logic [63:0] paddr;
    pend = 0; cnt = 0; paddr = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
    forever begin
      @(negedge clk); #2;
      imem_rsp_valid = 0; imem_rsp_err = 0;
      if (rst) begin
        pend = 0; imem_req_ready = 0;
        continue;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1; imem_rsp_data = mem_rd(paddr);
          imem_rsp_err = (paddr == err_addr); pend = 0;
        end else cnt--;
      end
      if (imem_req_valid && req_stall > 0) begin
        imem_req_ready = 0; req_stall--;
      end else imem_req_ready = 1;
      if (imem_req_valid && imem_req_ready) begin
        pend = 1; cnt = lat - 1; paddr = imem_req_addr;
      end else if (spur && !pend && !imem_rsp_valid) begin
        imem_rsp_valid = 1; imem_rsp_data = '1; imem_rsp_err = 1;
      end
    end
  end

  // Monitor: at negedge+3 all inputs for the coming edge are settled.
  initial begin : monitor
    bit req_hold, iss_hold;
    logic [63:0] hold_addr, hold_pc;
    logic [31:0] hold_inst;
    iss_t e;
    req_hold = 0; iss_hold = 0; hold_addr = '0; hold_pc = '0; hold_inst = '0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin req_hold = 0; iss_hold = 0; continue; end
      if (inst_valid) ivalid_cycles++;
      if (req_hold) begin
        check64("req_valid_held", 64'(imem_req_valid), 64'd1);
        check64("req_addr_stable", imem_req_addr, hold_addr);
      end
      if (iss_hold) begin
        check64("inst_valid_held", 64'(inst_valid), 64'd1);
        check64("inst_stable", 64'(inst), 64'(hold_inst));
        check64("inst_pc_stable", inst_pc, hold_pc);
      end
      if (imem_req_valid && imem_req_ready) begin
        req_hs++;
        if (req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
        end else check64("req_addr", imem_req_addr, req_q.pop_front());
      end
      if (inst_valid && inst_ready) begin
        iss_hs++;
        if (iss_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexpected: got inst %h expected no issue", inst);
        end else begin
          e = iss_q.pop_front();
          check64("inst", 64'(inst), 64'(e.inst));
          check64("inst_pc", inst_pc, e.pc);
        end
      end
      req_hold = imem_req_valid && !imem_req_ready; hold_addr = imem_req_addr;
      iss_hold = inst_valid && !inst_ready; hold_inst = inst; hold_pc = inst_pc;
    end
  end

  task automatic step;
    @(negedge clk); #1;
  endtask

  task automatic wait_issue(output int steps);
    steps = 0;
    while (!inst_valid && steps < 100) begin step; steps++; end
    if (!inst_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got inst_valid 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic check_reset_values;
    check64("rst_inst_valid", 64'(inst_valid), 64'd0);
    check64("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check64("rst_inst", 64'(inst), 64'd0);
    check64("rst_inst_pc", inst_pc, 64'd0);
    check64("rst_fetch_err", 64'(fetch_err), 64'd0);
    check64("rst_fetch_err_pc", fetch_err_pc, 64'd0);
    check64("rst_perf_fetch", perf_fetch_cnt, 64'd0);
    check64("rst_perf_stall", perf_stall_cnt, 64'd0);
  endtask

  // Reset is raised between edges so the checks prove it acts asynchronously.
  task automatic do_reset;
    rst = 1; inst_ready = 0; commit_valid = 0;
    #1;
    check_reset_values;
    step; step;
    rst = 0;
  endtask

  task automatic fetch(input logic [63:0] addr, input logic [31:0] exp_inst, input logic [63:0] pc,
                       input logic [63:0] dnpc, input int istall, input bit same, input bit junk,
                       output int steps);
    req_q.push_back(addr);
    iss_q.push_back('{exp_inst, pc});
    if (junk) begin commit_valid = 1; commit_dnpc = 64'hdead_0000; end
    wait_issue(steps);
    repeat (istall) step;
    inst_ready = 1; commit_valid = same; commit_dnpc = dnpc;
    step;
    inst_ready = 0; commit_valid = 0;
    if (!same) begin
      commit_valid = 1; commit_dnpc = dnpc;
      step;
      commit_valid = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin : main
    int s, h0, i0, v0, b;
    rst = 1; inst_ready = 0; commit_valid = 0; commit_dnpc = '0;
    step;
    do_reset;

    fetch(64'h8000_0000, 32'h00100093, 64'h8000_0000, 64'h8000_0004, 0, 1, 0, s);
    check64("first_issue_latency", 64'(s), 64'd2);
    fetch(64'h8000_0000, 32'h00000013, 64'h8000_0004, 64'h8000_0008, 0, 0, 0, s);

    // Back-pressure on both sides, plus ignored stray responses and commits.
    lat = 2; req_stall = 5; spur = 1; h0 = req_hs; i0 = iss_hs;
    fetch(64'h8000_0008, 32'hcafef00d, 64'h8000_0008, 64'h8000_000c, 4, 1, 1, s);
    spur = 0; lat = 1;
    check64("stall_req_handshakes", 64'(req_hs - h0), 64'd1);
    check64("stall_iss_handshakes", 64'(iss_hs - i0), 64'd1);
    fetch(64'h8000_0008, 32'h12345678, 64'h8000_000c, 64'h8000_1000, 0, 1, 0, s);

    err_addr = 64'h8000_1000;
    req_q.push_back(64'h8000_1000);
    v0 = ivalid_cycles;
    repeat (8) step;
    check64("err_fetch_err", 64'(fetch_err), 64'd1);
    check64("err_fetch_err_pc", fetch_err_pc, 64'h8000_1000);
    check64("err_no_issue", 64'(ivalid_cycles - v0), 64'd0);
    check64("err_inst_pc_kept", inst_pc, 64'h8000_000c);
    check64("err_no_req", 64'(imem_req_valid), 64'd0);
    do_reset;
    err_addr = '1;

    // Reset while a response is outstanding.
    fetch(64'h8000_0000, 32'h00100093, 64'h8000_0000, 64'h8000_0004, 0, 1, 0, s);
    lat = 4; req_q.push_back(64'h8000_0000); h0 = req_hs; b = 0;
    while (req_hs == h0 && b < 20) begin step; b++; end
    check64("midrsp_req_seen", 64'(req_hs - h0), 64'd1);
    check64("midrsp_inst_pc_before", inst_pc, 64'h8000_0000);
    do_reset;
    lat = 1;

    fetch(64'h8000_0000, 32'h00100093, 64'h8000_0000, 64'h8000_0102, 0, 0, 0, s);
    h0 = req_hs; v0 = ivalid_cycles;
    repeat (10) step;
    check64("mis_no_req", 64'(req_hs - h0), 64'd0);
    check64("mis_fetch_err", 64'(fetch_err), 64'd1);
    check64("mis_fetch_err_pc", fetch_err_pc, 64'h8000_0102);
    check64("mis_no_issue", 64'(ivalid_cycles - v0), 64'd0);
    do_reset;

    lat = 2;
    fetch(64'h8000_0000, 32'h00100093, 64'h8000_0000, 64'h8000_0004, 0, 1, 0, s);
    fetch(64'h8000_0000, 32'h00000013, 64'h8000_0004, 64'h8000_0008, 0, 1, 0, s);
    req_q.push_back(64'h8000_0008);
    iss_q.push_back('{32'hcafef00d, 64'h8000_0008});
    wait_issue(s);
`ifdef IFU_PERF_EN
    check64("perf_fetch_cnt", perf_fetch_cnt, 64'd3);
    check64("perf_stall_cnt", perf_stall_cnt, 64'd9);
`else
    check64("perf_fetch_cnt", perf_fetch_cnt, 64'd0);
    check64("perf_stall_cnt", perf_stall_cnt, 64'd0);
`endif
    inst_ready = 1; commit_valid = 1; commit_dnpc = 64'h8000_0102;
    step;
    inst_ready = 0; commit_valid = 0;
    repeat (3) step;

    check64("req_queue_drained", 64'(req_q.size()), 64'd0);
    check64("iss_queue_drained", 64'(iss_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
